actor_token_fifo: RTL and testbench
===================================

// Module: actor_token_fifo
// PURPOSE
//  Token channel between two dataflow actors. Write side is driven by a producer's output port
//  (DATA/SEND/COUNT, with RDY/ACK returned); read side drives a consumer's input port
//  (DATA/SEND/COUNT, with ACK returned). Show-ahead FIFO: head token is valid whenever R_SEND=1,
//  so a consumer may sample R_DATA and pulse R_ACK in the same cycle.
// PARAMETERS
//  DATA_WIDTH   16  token width in bits
//  DEPTH        64  token capacity; power of two, >=2
//  ADDR_WIDTH    6  log2(DEPTH)
//  COUNT_WIDTH  16  width of R_COUNT; DEPTH must be < 2**COUNT_WIDTH
// PORTS
//  CLK        in   1            clock, all state on rising edge
//  RESET      in   1            reset, asynchronous, active-high
//  W_DATA     in   DATA_WIDTH   producer token
//  W_SEND     in   1            producer writes one token this cycle
//  W_COUNT    in   COUNT_WIDTH  producer token count; only value 1 is legal, ignored otherwise
//  W_RDY      out  1            FIFO can accept a token this cycle (= !full)
//  W_ACK      out  1            token accepted this cycle (= W_SEND & W_RDY), combinational
//  R_DATA     out  DATA_WIDTH   head token; 0 when empty
//  R_SEND     out  1            head token valid (= !empty)
//  R_COUNT    out  COUNT_WIDTH  tokens currently stored
//  R_ACK      in   1            consumer pops head token this cycle
//  OVERFLOW   out  1            sticky: W_SEND seen while W_RDY=0
//  UNDERFLOW  out  1            sticky: R_ACK seen while R_SEND=0
// BEHAVIOUR
//  - Storage: DEPTH x DATA_WIDTH register array; wr_ptr, rd_ptr ADDR_WIDTH bits, wrap modulo DEPTH;
//    occupancy counter ADDR_WIDTH+1 bits, 0..DEPTH. R_COUNT = occupancy zero-extended.
//  - Reset (async assert, release sync to CLK): wr_ptr=rd_ptr=0, occupancy=0, OVERFLOW=UNDERFLOW=0.
//    Outputs during/after reset: W_RDY=1, W_ACK=0 (while W_SEND=0), R_SEND=0, R_DATA=0, R_COUNT=0.
//    Array contents need not be cleared. Reset mid-operation discards all stored tokens.
//  - Write: when W_SEND & W_RDY, mem[wr_ptr]<=W_DATA, wr_ptr++ at the clock edge.
//  - Read: when R_ACK & R_SEND, rd_ptr++ at the clock edge; R_DATA presents mem[rd_ptr]
//    combinationally (next token visible the cycle after the pop).
//  - Occupancy: +1 on write only, -1 on read only, unchanged on both or neither.
//  - Latency: token written at edge N appears on R_DATA/R_SEND after edge N (1 cycle write-to-read).
//  - Full (occupancy=DEPTH): W_RDY=0 regardless of a same-cycle R_ACK (no pass-through);
//    W_SEND while full: token dropped, W_ACK=0, OVERFLOW<=1.
//  - Empty (occupancy=0): R_SEND=0, R_DATA=0; R_ACK while empty: ignored, UNDERFLOW<=1;
//    a same-cycle write still lands (no bypass to R_DATA in that cycle).
//  - Simultaneous write+read when 0<occupancy<DEPTH: both proceed, occupancy unchanged.
//  - W_COUNT != 1 with W_SEND: token still written as one token (W_COUNT is not decoded).
//  - Order preserved strictly FIFO across pointer wrap-around.
// TESTING
//  1. Reset, write 0x0001..0x0003 on consecutive cycles, no R_ACK -> W_ACK=1 each cycle,
//     R_COUNT 1,2,3; R_DATA=0x0001 from cycle after first write.
//  2. Write 64 tokens 0x0100..0x013F -> W_RDY=0 after 64th, R_COUNT=64; 65th W_SEND -> W_ACK=0,
//     OVERFLOW=1, R_COUNT stays 64; drain with R_ACK held -> 0x0100..0x013F in order, then R_SEND=0.
//  3. Stream 200 tokens (write and R_ACK each cycle, starting half full) -> ptr wrap-around,
//     output sequence equals input sequence, R_COUNT constant at 32.
//  4. Full FIFO, W_SEND and R_ACK in same cycle -> write refused (W_ACK=0), R_COUNT=63 next cycle.
//  5. Empty FIFO, R_ACK=1 with W_SEND=1 W_DATA=0xBEEF -> UNDERFLOW=1, R_COUNT=1, R_DATA=0xBEEF next cycle.
//  6. 10 tokens stored, assert RESET asynchronously mid-cycle -> R_SEND=0, R_COUNT=0, W_RDY=1,
//     flags 0 immediately; after release, first new write is first token read.

Source files
------------

// File: rtl/actor_token_fifo.sv
// Show-ahead token FIFO between a producer output port and a consumer input port.
// Head token is presented combinationally so the consumer can sample and pop in one cycle.
module actor_token_fifo #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 64,
   parameter int ADDR_WIDTH  = 6,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [DATA_WIDTH-1:0]  W_DATA,
   input  logic                   W_SEND,
   input  logic [COUNT_WIDTH-1:0] W_COUNT,
   output logic                   W_RDY,
   output logic                   W_ACK,
   output logic [DATA_WIDTH-1:0]  R_DATA,
   output logic                   R_SEND,
   output logic [COUNT_WIDTH-1:0] R_COUNT,
   input  logic                   R_ACK,
   output logic                   OVERFLOW,
   output logic                   UNDERFLOW
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   occ_q, occ_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  full_s, empty_s, wr_en_s, rd_en_s;
   logic                  unused_w_count_s;

   // W_COUNT is not decoded: every accepted send is exactly one token.
   assign unused_w_count_s = ^W_COUNT;

   assign full_s  = (occ_q == FULL_CNT);
   assign empty_s = (occ_q == {(ADDR_WIDTH+1){1'b0}});
   assign wr_en_s = W_SEND & ~full_s;
   assign rd_en_s = R_ACK & ~empty_s;

   assign W_RDY     = ~full_s;
   assign W_ACK     = wr_en_s;
   assign R_SEND    = ~empty_s;
   assign R_DATA    = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign R_COUNT   = {{(COUNT_WIDTH-ADDR_WIDTH-1){1'b0}}, occ_q};
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;

   // Next-state for pointers, occupancy and sticky error flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
         rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
         2'b10:   occ_d = occ_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase
      if (W_SEND & full_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      if (R_ACK & empty_s) begin
         unf_d = 1'b1;
      end else begin
         unf_d = unf_q;
      end
   end

   // Control state register; reset discards all stored tokens.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= {ADDR_WIDTH{1'b0}};
         rd_ptr_q <= {ADDR_WIDTH{1'b0}};
         occ_q    <= {(ADDR_WIDTH+1){1'b0}};
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Token storage; contents are don't-care while the slot is not occupied.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= W_DATA;
      end
   end

endmodule

// File: tb/tb_actor_token_fifo.sv
// Directed self-checking bench for actor_token_fifo; inputs change and outputs are
// sampled 1-3 time units after the rising edge, away from the active edge.
module tb_actor_token_fifo;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] W_DATA;
   logic        W_SEND;
   logic [15:0] W_COUNT;
   logic        W_RDY, W_ACK;
   logic [15:0] R_DATA;
   logic        R_SEND;
   logic [15:0] R_COUNT;
   logic        R_ACK;
   logic        OVERFLOW, UNDERFLOW;

   int n_tests = 0;
   int n_fail  = 0;

   actor_token_fifo dut (
      .CLK(CLK), .RESET(RESET),
      .W_DATA(W_DATA), .W_SEND(W_SEND), .W_COUNT(W_COUNT),
      .W_RDY(W_RDY), .W_ACK(W_ACK),
      .R_DATA(R_DATA), .R_SEND(R_SEND), .R_COUNT(R_COUNT), .R_ACK(R_ACK),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1; W_SEND = 1'b0; R_ACK = 1'b0; W_DATA = 16'h0000; W_COUNT = 16'h0001;
      tick();
      @(negedge CLK);
      RESET = 1'b0;
      tick();
   endtask

   task automatic fill(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         W_SEND = 1'b1; W_DATA = base + 16'(i);
         #1 check("fill_ack", {31'd0, W_ACK}, 32'd1);
         tick();
      end
      W_SEND = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; W_SEND = 1'b0; R_ACK = 1'b0; W_DATA = 16'h0000; W_COUNT = 16'h0001;
      #2;
      check("rst_rdy",   {31'd0, W_RDY},     32'd1);
      check("rst_ack",   {31'd0, W_ACK},     32'd0);
      check("rst_send",  {31'd0, R_SEND},    32'd0);
      check("rst_data",  {16'd0, R_DATA},    32'd0);
      check("rst_count", {16'd0, R_COUNT},   32'd0);
      check("rst_ovf",   {31'd0, OVERFLOW},  32'd0);
      check("rst_unf",   {31'd0, UNDERFLOW}, 32'd0);

      // 1: three consecutive writes, head stays at the first token
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         W_SEND = 1'b1; W_DATA = 16'(i);
         #1 check("t1_ack", {31'd0, W_ACK}, 32'd1);
         tick();
         check("t1_count", {16'd0, R_COUNT}, 32'(i));
         check("t1_head",  {16'd0, R_DATA},  32'h0001);
      end
      W_SEND = 1'b0;

      // 2: fill to capacity, overflow attempt, drain in order
      do_reset();
      fill(64, 16'h0100);
      check("t2_rdy",   {31'd0, W_RDY},   32'd0);
      check("t2_count", {16'd0, R_COUNT}, 32'd64);
      W_SEND = 1'b1; W_DATA = 16'hDEAD;
      #1 check("t2_ovf_ack", {31'd0, W_ACK}, 32'd0);
      tick();
      W_SEND = 1'b0;
      check("t2_ovf",       {31'd0, OVERFLOW}, 32'd1);
      check("t2_count_ovf", {16'd0, R_COUNT},  32'd64);
      R_ACK = 1'b1;
      for (int i = 0; i < 64; i++) begin
         check("t2_drain_send", {31'd0, R_SEND}, 32'd1);
         check("t2_drain_data", {16'd0, R_DATA}, 32'h0100 + 32'(i));
         tick();
      end
      R_ACK = 1'b0;
      check("t2_empty_send", {31'd0, R_SEND},    32'd0);
      check("t2_empty_data", {16'd0, R_DATA},    32'd0);
      check("t2_no_unf",     {31'd0, UNDERFLOW}, 32'd0);

      // 3: steady streaming at half full across pointer wrap
      do_reset();
      fill(32, 16'h2000);
      for (int i = 0; i < 200; i++) begin
         W_SEND = 1'b1; R_ACK = 1'b1; W_DATA = 16'h2000 + 16'(32 + i);
         #1 check("t3_head", {16'd0, R_DATA}, 32'h2000 + 32'(i));
         tick();
         check("t3_count", {16'd0, R_COUNT}, 32'd32);
      end
      W_SEND = 1'b0; R_ACK = 1'b0;

      // 4: full with same-cycle write and pop: no pass-through
      do_reset();
      fill(64, 16'h0100);
      W_SEND = 1'b1; R_ACK = 1'b1; W_DATA = 16'hCAFE;
      #1 check("t4_ack", {31'd0, W_ACK}, 32'd0);
      tick();
      W_SEND = 1'b0; R_ACK = 1'b0;
      check("t4_count", {16'd0, R_COUNT},  32'd63);
      check("t4_head",  {16'd0, R_DATA},   32'h0101);
      check("t4_ovf",   {31'd0, OVERFLOW}, 32'd1);

      // 5: pop on empty with same-cycle write; then a write with W_COUNT != 1
      do_reset();
      W_SEND = 1'b1; R_ACK = 1'b1; W_DATA = 16'hBEEF;
      #1 check("t5_nobypass_send", {31'd0, R_SEND}, 32'd0);
      check("t5_nobypass_data", {16'd0, R_DATA}, 32'd0);
      tick();
      R_ACK = 1'b0;
      check("t5_unf",   {31'd0, UNDERFLOW}, 32'd1);
      check("t5_count", {16'd0, R_COUNT},   32'd1);
      check("t5_data",  {16'd0, R_DATA},    32'h0000BEEF);
      W_DATA = 16'h1234; W_COUNT = 16'h0003;
      tick();
      W_SEND = 1'b0; W_COUNT = 16'h0001;
      check("t5_wcount", {16'd0, R_COUNT}, 32'd2);
      check("t5_head",   {16'd0, R_DATA},  32'h0000BEEF);

      // 6: asynchronous reset mid-cycle with tokens stored and a flag set
      do_reset();
      R_ACK = 1'b1;
      tick();
      R_ACK = 1'b0;
      check("t6_unf_pre", {31'd0, UNDERFLOW}, 32'd1);
      fill(10, 16'h0A00);
      check("t6_count_pre", {16'd0, R_COUNT}, 32'd10);
      #2 RESET = 1'b1;
      #1;
      check("t6_send",  {31'd0, R_SEND},    32'd0);
      check("t6_count", {16'd0, R_COUNT},   32'd0);
      check("t6_rdy",   {31'd0, W_RDY},     32'd1);
      check("t6_data",  {16'd0, R_DATA},    32'd0);
      check("t6_unf",   {31'd0, UNDERFLOW}, 32'd0);
      check("t6_ovf",   {31'd0, OVERFLOW},  32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      tick();
      W_SEND = 1'b1; W_DATA = 16'h5555;
      tick();
      W_DATA = 16'h6666;
      tick();
      W_SEND = 1'b0;
      check("t6_first",    {16'd0, R_DATA},  32'h5555);
      check("t6_count_po", {16'd0, R_COUNT}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
